hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage MIPS core; sits beside ID.
//  Detects load-use and branch-in-ID data hazards against the instruction in EX.
//  Inserts multi-cycle stalls sized to the data-memory load latency.
//  Freezes the whole pipeline while data memory is busy.
//  Drives PC write enable, IF/ID write enable, ID/EX flush and a global freeze.
// PARAMETERS
//  ADDR_W    5  register-address width
//  LOAD_LAT  1  stall cycles for load-use (1 = classic single bubble); range 1..7
//  BR_EXTRA  1  extra stall cycles when a branch in ID depends on a load in EX; range 0..3
//  BR_ALU    1  stall cycles when a branch in ID depends on an ALU result in EX; 0 disables
// PORTS
//  clk          in   1       core clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  mem_read_ex  in   1       EX instruction is a load
//  reg_write_ex in   1       EX instruction writes a register
//  dst_addr_ex  in   ADDR_W  EX destination register (rt for load, rd/rt otherwise)
//  rs_addr_id   in   ADDR_W  ID source rs
//  rt_addr_id   in   ADDR_W  ID source rt
//  use_rt_id    in   1       ID instruction actually reads rt (0 for I-type ALU / load)
//  branch_id    in   1       ID instruction is a branch resolved in ID
//  mem_ready    in   1       data memory can complete this cycle
//  pc_write     out  1       PC update enable
//  if_id_write  out  1       IF/ID register write enable
//  id_ex_flush  out  1       replace ID/EX contents with a bubble
//  freeze       out  1       hold all pipeline registers (memory wait)
//  stall_busy   out  1       multi-cycle stall in progress (debug/perf counter)
// BEHAVIOUR
//  States: RUN, STALL; counter cnt width 3 bits.
//  match(a) = (a != 0) && (a == rs_addr_id || (use_rt_id && a == rt_addr_id)); r0 never hazards.
//  Hazard length N, evaluated in RUN only:
//   - mem_read_ex && match(dst_addr_ex): N = LOAD_LAT + (branch_id ? BR_EXTRA : 0).
//   - else branch_id && reg_write_ex && match(dst_addr_ex): N = BR_ALU.
//   - else N = 0.
//  Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
//  Idle outputs: pc_write=1, if_id_write=1, id_ex_flush=0.
//  RUN, N=0: idle outputs; stay in RUN.
//  RUN, N>=1: stall outputs in the same cycle (combinational, zero latency).
//   - N==1: stay in RUN.
//   - N>1: go to STALL with cnt <= N-2.
//  STALL: stall outputs; hazard inputs ignored.
//   - cnt==0: go to RUN.
//   - else: cnt <= cnt-1.
//  After a stall, EX holds a bubble, so the ID instruction is not re-flagged.
//  Total stall = exactly N cycles.
//  freeze = !mem_ready, with top priority:
//   - freeze=1 forces pc_write=0, if_id_write=0, id_ex_flush=0.
//   - state and cnt hold; no new hazard is evaluated.
//   - stall accounting resumes unchanged when mem_ready rises.
//  stall_busy = (state == STALL).
//  Reset (rst_n low, asynchronous, any state):
//   - state=RUN, cnt=0.
//   - Outputs forced: pc_write=0, if_id_write=0, id_ex_flush=1, freeze=0, stall_busy=0.
//   - Idle/hazard decode resumes on the first edge after release.
//  Reset mid-stall abandons the stall; no residual bubbles after release.
// STRUCTURE
//  Package hazard_pkg:
//   - state enum {RUN, STALL}
//   - CNT_W = 3
//   - function hz_match(addr, rs, rt, use_rt)
//  Single module. The match/N decode is combinational; state+cnt is one registered block.
//  No sub-module required.
// TESTING
//  1. lw $2 in EX, ID add reads rs=$2, LOAD_LAT=1 -> 1 stall cycle, then RUN, idle outputs.
//  2. LOAD_LAT=3, same load-use -> stall outputs 3 consecutive cycles, stall_busy high cycles 2-3.
//  3. Load to $0 with ID rs=$0; also ID addi (use_rt_id=0) with rt==dst -> no stall in either case.
//  4. beq in ID with rs = lw dst in EX, LOAD_LAT=1, BR_EXTRA=1 -> 2 stall cycles.
//     Same with ALU producer -> 1 stall cycle.
//  5. mem_ready=0 for 2 cycles during cycle 2 of a 3-cycle stall -> freeze=1 for 2 cycles;
//     total stall cycles still 3; flush low while frozen.
//  6. rst_n low mid-STALL (cnt=1) -> forced reset outputs immediately;
//     after release, no hazard inputs -> idle outputs, stall_busy=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Register-address match that never flags r0.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

  localparam int CNT_W = 3;
  localparam int N_W   = 4;
  localparam int MAX_AW = 16;

  // Longest stall the counter can express: cnt holds N-2.
  localparam int N_MAX = (1 << CNT_W) + 1;

  function automatic logic hz_match(
    input logic [MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0] rs,
    input logic [MAX_AW-1:0] rt,
    input logic              use_rt
  );
    logic w_hit;
    w_hit = (addr == rs) || (use_rt && (addr == rt));
    return (addr != '0) && w_hit;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch hazard controller for the 5-stage core.
// Issues N-cycle stalls and freezes the pipe on memory wait.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_EXTRA = 1,
  parameter int BR_ALU   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_ex,
  input  logic              reg_write_ex,
  input  logic [ADDR_W-1:0] dst_addr_ex,
  input  logic [ADDR_W-1:0] rs_addr_id,
  input  logic [ADDR_W-1:0] rt_addr_id,
  input  logic              use_rt_id,
  input  logic              branch_id,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_flush,
  output logic              freeze,
  output logic              stall_busy
);

  hz_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live;

  logic             w_match;
  logic             w_ld_hit;
  logic             w_br_hit;
  logic [N_W-1:0]   w_n_raw;
  logic [N_W-1:0]   w_n;
  logic             w_stall;
  logic             w_adv;

  localparam logic [N_W-1:0] LD_N  = N_W'(LOAD_LAT);
  localparam logic [N_W-1:0] BRX_N = N_W'(BR_EXTRA);
  localparam logic [N_W-1:0] ALU_N = N_W'(BR_ALU);
  localparam logic [N_W-1:0] CAP_N = N_W'(N_MAX);

  // Hazard detection and stall-length decode against EX.
  always_comb begin
    w_match  = hz_match(MAX_AW'(dst_addr_ex),
                        MAX_AW'(rs_addr_id),
                        MAX_AW'(rt_addr_id),
                        use_rt_id);
    w_ld_hit = mem_read_ex && w_match;
    w_br_hit = branch_id && reg_write_ex && w_match;
    w_n_raw  = '0;
    if (w_ld_hit) begin
      w_n_raw = LD_N + (branch_id ? BRX_N : '0);
    end else if (w_br_hit) begin
      w_n_raw = ALU_N;
    end
    // Saturate so N-2 always fits the counter.
    w_n = (w_n_raw > CAP_N) ? CAP_N : w_n_raw;
  end

  // Stall is active while counting or on a fresh hazard in RUN.
  always_comb begin
    w_stall = (r_state == STALL) || (w_n != '0);
    w_adv   = r_live && mem_ready;
  end

  // Output priority: reset window, then freeze, then stall/idle.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    id_ex_flush = 1'b1;
    freeze      = 1'b0;
    stall_busy  = 1'b0;
    if (rst_n && r_live) begin
      stall_busy = (r_state == STALL);
      if (!mem_ready) begin
        freeze      = 1'b1;
        id_ex_flush = 1'b0;
      end else begin
        pc_write    = !w_stall;
        if_id_write = !w_stall;
        id_ex_flush = w_stall;
      end
    end
  end

  // Stall sequencer; holds while frozen, decode starts after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_adv) begin
        unique case (r_state)
          RUN: begin
            if (w_n > N_W'(1)) begin
              r_state <= STALL;
              r_cnt   <= CNT_W'(w_n - N_W'(2));
            end
          end
          STALL: begin
            if (r_cnt == '0) begin
              r_state <= RUN;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
